// File: rtl/sr_write_sequencer.sv
// Write sequencer for the set/reset flip-flop register bank.
// Drives non-overlapping clear then set pulses and verifies the readback.
module sr_write_sequencer #(
    parameter int NREG      = 4,
    parameter int WIDTH     = 2,
    parameter int PULSE_CYC = 1,
    parameter int GAP_CYC   = 1
) (
    input  logic                     clk,
    input  logic                     r,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [$clog2(NREG)-1:0]  req_addr,
    input  logic [WIDTH-1:0]         req_data,
    output logic [NREG*WIDTH-1:0]    s_pulse,
    output logic [NREG*WIDTH-1:0]    r_pulse,
    input  logic [NREG*WIDTH-1:0]    q_in,
    output logic                     busy,
    output logic                     done,
    output logic                     err
);

    localparam int AW   = $clog2(NREG);
    localparam int NW   = NREG * WIDTH;
    localparam int MAXC = (PULSE_CYC > GAP_CYC) ? PULSE_CYC : GAP_CYC;
    localparam int CW   = $clog2(MAXC + 1);

    localparam logic [CW-1:0] P_LD = CW'(PULSE_CYC - 1);
    localparam logic [CW-1:0] G_LD = CW'(GAP_CYC - 1);

    typedef enum logic [2:0] {
        IDLE,
        CLR,
        GAP1,
        SET,
        GAP2,
        VERIFY
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [AW-1:0]     addr_q, addr_d;
    logic [WIDTH-1:0]  data_q, data_d;
    logic [WIDTH-1:0]  q_sel;
    logic [NW-1:0]     s_d, r_d;
    logic              done_d, err_d, ready_d;
    logic              addr_bad;

    // Addresses beyond the bank exist only when NREG is not a power of two.
    if ((1 << AW) == NREG) begin : g_pow2
        assign addr_bad = 1'b0;
    end else begin : g_npow2
        assign addr_bad = ({{(32-AW){1'b0}}, req_addr} >= 32'(NREG));
    end

    // Readback slice of the register being written.
    always_comb begin
        q_sel = '0;
        for (int a = 0; a < NREG; a++) begin
            if (addr_q == AW'(a)) q_sel = q_in[a*WIDTH +: WIDTH];
        end
    end

    // Next state, phase counter and next registered outputs.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        data_d  = data_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    addr_d = req_addr;
                    data_d = req_data;
                    if (addr_bad) begin
                        done_d = 1'b1;
                        err_d  = 1'b1;
                    end else begin
                        state_d = CLR;
                        cnt_d   = P_LD;
                    end
                end
            end
            CLR: begin
                if (cnt_q == '0) begin
                    state_d = GAP1;
                    cnt_d   = G_LD;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            GAP1: begin
                if (cnt_q == '0) begin
                    state_d = SET;
                    cnt_d   = P_LD;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            SET: begin
                if (cnt_q == '0) begin
                    state_d = GAP2;
                    cnt_d   = G_LD;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            GAP2: begin
                if (cnt_q == '0) begin
                    state_d = VERIFY;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            VERIFY: begin
                state_d = IDLE;
                cnt_d   = '0;
                done_d  = 1'b1;
                err_d   = (q_sel != data_q);
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        ready_d = (state_d == IDLE);
        s_d     = '0;
        r_d     = '0;
        for (int a = 0; a < NREG; a++) begin
            if (addr_d == AW'(a)) begin
                if (state_d == CLR) r_d[a*WIDTH +: WIDTH] = '1;
                if (state_d == SET) s_d[a*WIDTH +: WIDTH] = data_d;
            end
        end
    end

    // State and registered outputs; reset aborts any write in flight.
    always_ff @(posedge clk) begin
        if (!r) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            req_ready <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            s_pulse   <= '0;
            r_pulse   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            req_ready <= ready_d;
            busy      <= !ready_d;
            done      <= done_d;
            err       <= err_d;
            s_pulse   <= s_d;
            r_pulse   <= r_d;
        end
    end

endmodule

// File: tb/tb_sr_write_sequencer.sv
// Scoreboard bench for sr_write_sequencer: a 4x2 bank with 1-cycle phases
// and a 3x2 bank with 3-cycle pulses and 2-cycle gaps.
module tb_sr_write_sequencer;

    typedef struct {
        int cyc;
        bit err;
    } exp_t;

    localparam int PC[2] = '{1, 3};
    localparam int GC[2] = '{1, 2};
    localparam int NR[2] = '{4, 3};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       vld[2];
    logic [1:0] addr[2];
    logic [1:0] data[2];
    logic [1:0] stuck[2];

    logic       rdy0, rdy1, bsy0, bsy1, dn0, dn1, er0, er1;
    logic [7:0] s0, r0, q0;
    logic [5:0] s1, r1, q1;

    logic [7:0] bank[2];
    logic [7:0] cur_mask[2];

    logic [7:0] exp_s[2][64];
    logic [7:0] exp_r[2][64];
    bit         exp_busy[2][64];
    exp_t       sbq0[$];
    exp_t       sbq1[$];
    int         next_free[2];
    int         acc_cnt[2];
    int         edge_n;
    bit         armed;
    int         passed;
    int         total;

    assign q0 = bank[0] & ~cur_mask[0];
    assign q1 = bank[1][5:0] & ~cur_mask[1][5:0];

    sr_write_sequencer #(
        .NREG(4), .WIDTH(2), .PULSE_CYC(1), .GAP_CYC(1)
    ) dut_a (
        .clk(clk), .r(rst_n), .req_valid(vld[0]), .req_ready(rdy0),
        .req_addr(addr[0]), .req_data(data[0]), .s_pulse(s0),
        .r_pulse(r0), .q_in(q0), .busy(bsy0), .done(dn0), .err(er0)
    );

    sr_write_sequencer #(
        .NREG(3), .WIDTH(2), .PULSE_CYC(3), .GAP_CYC(2)
    ) dut_b (
        .clk(clk), .r(rst_n), .req_valid(vld[1]), .req_ready(rdy1),
        .req_addr(addr[1]), .req_data(data[1]), .s_pulse(s1),
        .r_pulse(r1), .q_in(q1), .busy(bsy1), .done(dn1), .err(er1)
    );

    task automatic chk(string nm, int d, int act, int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s dut%0d cyc %0d: got %0h want %0h",
                      nm, d, edge_n, act, exp);
    endtask

    function automatic int qn(int d);
        return (d == 0) ? sbq0.size() : sbq1.size();
    endfunction

    function automatic exp_t qfront(int d);
        return (d == 0) ? sbq0[0] : sbq1[0];
    endfunction

    function automatic void qpop(int d);
        if (d == 0) void'(sbq0.pop_front());
        else void'(sbq1.pop_front());
    endfunction

    // Reference model: per request, lay out the expected pulse timeline.
    task automatic model_edge(int d);
        exp_t x;
        int   a, dt, lat;
        if (!rst_n) begin
            for (int i = 0; i < 64; i++) begin
                exp_s[d][i]    = '0;
                exp_r[d][i]    = '0;
                exp_busy[d][i] = 1'b0;
            end
            if (d == 0) sbq0.delete();
            else sbq1.delete();
            next_free[d] = edge_n + 1;
        end else if (vld[d] && edge_n >= next_free[d]) begin
            acc_cnt[d]++;
            a  = int'(addr[d]);
            dt = int'(data[d]);
            if (a >= NR[d]) begin
                x.cyc = edge_n;
                x.err = 1'b1;
                next_free[d] = edge_n + 1;
            end else begin
                for (int k = 0; k < PC[d]; k++) begin
                    exp_r[d][(edge_n + k) % 64] = 8'(3) << (a * 2);
                    exp_s[d][(edge_n + PC[d] + GC[d] + k) % 64] =
                        8'(dt) << (a * 2);
                end
                lat = 2 * PC[d] + 2 * GC[d] + 1;
                for (int k = 0; k < lat; k++)
                    exp_busy[d][(edge_n + k) % 64] = 1'b1;
                cur_mask[d] <= 8'(stuck[d]) << (a * 2);
                x.cyc = edge_n + lat;
                x.err = ((dt & int'(stuck[d])) != 0);
                next_free[d] = edge_n + lat + 1;
            end
            if (d == 0) sbq0.push_back(x);
            else sbq1.push_back(x);
        end
    endtask

    // Edge process: flip-flop bank plant plus the reference model.
    initial begin
        bank[0] = '0;
        bank[1] = '0;
        cur_mask[0] = '0;
        cur_mask[1] = '0;
        forever begin
            @(posedge clk);
            edge_n++;
            bank[0] <= (bank[0] | s0) & ~r0;
            bank[1] <= (bank[1] | {2'b00, s1}) & ~{2'b00, r1};
            for (int d = 0; d < 2; d++) model_edge(d);
            if (!rst_n) armed = 1'b1;
        end
    end

    // Monitor: compare every cycle and pop the scoreboard on done.
    initial begin
        logic [7:0] so, ro;
        logic       rd, bs, dn, er;
        exp_t       e;
        int         i;
        forever begin
            @(negedge clk);
            if (armed) begin
                i = edge_n % 64;
                for (int d = 0; d < 2; d++) begin
                    so = (d == 0) ? s0 : {2'b00, s1};
                    ro = (d == 0) ? r0 : {2'b00, r1};
                    rd = (d == 0) ? rdy0 : rdy1;
                    bs = (d == 0) ? bsy0 : bsy1;
                    dn = (d == 0) ? dn0 : dn1;
                    er = (d == 0) ? er0 : er1;
                    chk("s_pulse", d, int'(so), int'(exp_s[d][i]));
                    chk("r_pulse", d, int'(ro), int'(exp_r[d][i]));
                    chk("s_and_r", d, int'(so & ro), 0);
                    chk("req_ready", d, int'(rd), int'(!exp_busy[d][i]));
                    chk("busy", d, int'(bs), int'(exp_busy[d][i]));
                    exp_s[d][i]    = '0;
                    exp_r[d][i]    = '0;
                    exp_busy[d][i] = 1'b0;
                    if (dn) begin
                        if (qn(d) == 0) begin
                            chk("done_unexpected", d, int'(dn), 0);
                        end else begin
                            e = qfront(d);
                            qpop(d);
                            chk("done_cycle", d, edge_n, e.cyc);
                            chk("err", d, int'(er), int'(e.err));
                        end
                    end else begin
                        chk("err_without_done", d, int'(er), 0);
                        if (qn(d) > 0) begin
                            e = qfront(d);
                            if (e.cyc < edge_n) begin
                                chk("done_missing", d, int'(dn), 1);
                                qpop(d);
                            end
                        end
                    end
                end
            end
        end
    end

    task automatic issue(int d, int a, int dt, int st, bit hold);
        int n0, k;
        @(negedge clk);
        vld[d]   = 1'b1;
        addr[d]  = 2'(a);
        data[d]  = 2'(dt);
        stuck[d] = 2'(st);
        n0 = acc_cnt[d];
        k  = 0;
        while (acc_cnt[d] == n0 && k < 40) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (acc_cnt[d] == n0) chk("accept_timeout", d, acc_cnt[d], n0 + 1);
        if (!hold) begin
            @(negedge clk);
            vld[d] = 1'b0;
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
    endtask

    task automatic rand_issue(int d);
        int st;
        st = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0;
        issue(d, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
              st, bit'($urandom_range(0, 1)));
    endtask

    initial begin
        rst_n = 1'b0;
        vld[0] = 1'b1;
        vld[1] = 1'b1;
        for (int d = 0; d < 2; d++) begin
            addr[d]  = 2'd1;
            data[d]  = 2'd3;
            stuck[d] = 2'd0;
        end
        repeat (3) @(negedge clk);
        rst_n  = 1'b1;
        vld[0] = 1'b0;
        vld[1] = 1'b0;
        repeat (2) @(negedge clk);

        issue(0, 2, 2, 0, 1'b0);
        issue(0, 2, 2, 3, 1'b0);
        issue(0, 1, 1, 0, 1'b1);
        issue(0, 3, 3, 0, 1'b1);
        issue(0, 0, 2, 0, 1'b0);

        issue(0, 1, 3, 0, 1'b1);
        @(negedge clk);
        vld[0] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);

        repeat (60) rand_issue(0);
        @(negedge clk);
        vld[0] = 1'b0;

        issue(1, 3, 1, 0, 1'b0);
        issue(1, 1, 2, 0, 1'b1);
        issue(1, 3, 0, 0, 1'b1);
        issue(1, 2, 3, 2, 1'b0);
        repeat (40) rand_issue(1);
        @(negedge clk);
        vld[1] = 1'b0;

        repeat (20) @(negedge clk);
        for (int d = 0; d < 2; d++) chk("scoreboard_drained", d, qn(d), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
